// File: rtl/onehot_pkg.sv
// Shared types and the one-hot encode rule for the encoder pipeline.
// The rule lives here once so the core and any other users agree on it.
package onehot_pkg;

   localparam int MAX_N = 64;
   localparam int MAX_W = 6;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } occ_e;

   typedef struct packed {
      logic [MAX_W-1:0] code;
      logic             err;
   } enc_t;

   // Lowest set bit wins; anything other than exactly one bit is an error.
   function automatic enc_t onehot_encode(input logic [MAX_N-1:0] v);
      enc_t        r;
      int unsigned cnt;
      r.code = '0;
      cnt    = 0;
      for (int i = MAX_N - 1; i >= 0; i--) begin
         if (v[i]) begin
            r.code = MAX_W'(i);
            cnt    = cnt + 1;
         end
      end
      r.err = (cnt != 1);
      return r;
   endfunction

endpackage

// File: rtl/onehot_encoder_if.sv
// Upstream/downstream handshake bundle for the one-hot encoder.
// slave is the encoder's view; master is the environment's view.
interface onehot_encoder_if #(
   parameter int N_IN      = 8,
   parameter int ERR_CNT_W = 8
);

   localparam int W = $clog2(N_IN);

   logic                 in_valid;
   logic                 in_ready;
   logic [N_IN-1:0]      in_vec;
   logic                 out_valid;
   logic                 out_ready;
   logic [W-1:0]         out_code;
   logic                 out_err;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport slave (
      input  in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_code, out_err, err_cnt
   );

   modport master (
      output in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_code, out_err, err_cnt
   );

endinterface

// File: rtl/onehot_encoder_core.sv
// Combinational one-hot to binary encode with malformed-vector flag.
// Widens the input to the package width and narrows the code back.
module onehot_encoder_core
   import onehot_pkg::*;
#(
   parameter int N_IN = 8,
   parameter int W    = $clog2(N_IN)
) (
   input  logic [N_IN-1:0] vec_i,
   output logic [W-1:0]    code_o,
   output logic            err_o
);

   logic [MAX_N-1:0] vec_x;
   enc_t             r;

   assign vec_x  = MAX_N'(vec_i);
   assign r      = onehot_encode(vec_x);
   assign code_o = W'(r.code);
   assign err_o  = r.err;

endmodule

// File: rtl/onehot_encoder.sv
// Pipelined one-hot encoder: main output register plus one skid entry.
// Saturating counter tracks accepted malformed vectors.
module onehot_encoder
   import onehot_pkg::*;
#(
   parameter int N_IN      = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   onehot_encoder_if.slave  bus
);

   localparam int W = $clog2(N_IN);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   occ_e                 state_q, state_d;
   logic [W-1:0]         main_code_q, main_code_d;
   logic [W-1:0]         skid_code_q, skid_code_d;
   logic                 main_err_q, main_err_d;
   logic                 skid_err_q, skid_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [W-1:0] enc_code;
   logic         enc_err;
   logic         in_ready;
   logic         out_valid;
   logic         accept;
   logic         xfer;

   onehot_encoder_core #(
      .N_IN (N_IN),
      .W    (W)
   ) u_core (
      .vec_i  (bus.in_vec),
      .code_o (enc_code),
      .err_o  (enc_err)
   );

   assign in_ready  = (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign accept    = bus.in_valid && in_ready;
   assign xfer      = out_valid && bus.out_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_code  = main_code_q;
   assign bus.out_err   = main_err_q;
   assign bus.err_cnt   = err_cnt_q;

   always_comb begin
      state_d     = state_q;
      main_code_d = main_code_q;
      main_err_d  = main_err_q;
      skid_code_d = skid_code_q;
      skid_err_d  = skid_err_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d     = ONE;
               main_code_d = enc_code;
               main_err_d  = enc_err;
            end
         end
         ONE: begin
            // Full-rate case reloads main directly and never visits TWO.
            if (accept && xfer) begin
               main_code_d = enc_code;
               main_err_d  = enc_err;
            end else if (accept) begin
               state_d     = TWO;
               skid_code_d = enc_code;
               skid_err_d  = enc_err;
            end else if (xfer) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (xfer) begin
               state_d     = ONE;
               main_code_d = skid_code_q;
               main_err_d  = skid_err_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && enc_err && (err_cnt_q != CNT_MAX))
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         main_code_q <= '0;
         main_err_q  <= 1'b0;
         skid_code_q <= '0;
         skid_err_q  <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         main_code_q <= main_code_d;
         main_err_q  <= main_err_d;
         skid_code_q <= skid_code_d;
         skid_err_q  <= skid_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_onehot_encoder.sv
// Self-checking bench for onehot_encoder: queue model plus directed vectors.
// A second instance with a 4-bit counter covers saturation.
module tb_onehot_encoder;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   mcnt;

   logic [3:0] q[$];
   logic [2:0] got[$];

   onehot_encoder_if #(.N_IN(8), .ERR_CNT_W(8)) bus ();
   onehot_encoder_if #(.N_IN(8), .ERR_CNT_W(4)) bus2 ();

   onehot_encoder #(.N_IN(8), .ERR_CNT_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   onehot_encoder #(.N_IN(8), .ERR_CNT_W(4)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   // {err, code}: err unless exactly one bit; code = lowest set bit.
   function automatic logic [3:0] model(input logic [7:0] v);
      int lo;
      int n;
      lo = 0;
      n  = $countones(v);
      while (lo < 8 && !v[lo]) lo++;
      if (n == 0) return 4'b1000;
      return {n != 1, 3'(lo)};
   endfunction

   // The existing 3-to-8 decoder feeding this block.
   function automatic logic [7:0] dec3to8(input logic a, input logic b,
                                          input logic cin);
      logic [7:0] one;
      one = 8'd1;
      return one << {a, b, cin};
   endfunction

   always @(negedge clk) begin
      logic acc;
      logic [3:0] e;
      if (!rst_n) begin
         q.delete();
         mcnt = 0;
      end else begin
         chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
         chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
         chk("err_cnt", 32'(bus.err_cnt), 32'(mcnt));
         acc = bus.in_valid && (q.size() < 2);
         if (q.size() > 0) begin
            chk("out_code", 32'(bus.out_code), 32'(q[0][2:0]));
            chk("out_err", 32'(bus.out_err), 32'(q[0][3]));
            if (bus.out_ready) begin
               got.push_back(bus.out_code);
               void'(q.pop_front());
            end
         end
         if (acc) begin
            e = model(bus.in_vec);
            q.push_back(e);
            if (e[3] && mcnt < 255) mcnt++;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] exp_bp[3];
      checks   = 0;
      failures = 0;
      mcnt     = 0;
      rst_n    = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_vec     = '0;
      bus.out_ready  = 1'b1;
      bus2.in_valid  = 1'b0;
      bus2.in_vec    = '0;
      bus2.out_ready = 1'b1;

      #2;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_out_code", 32'(bus.out_code), 0);
      chk("rst_out_err", 32'(bus.out_err), 0);
      chk("rst_err_cnt", 32'(bus.err_cnt), 0);
      #1 rst_n = 1'b1;
      cyc();

      // Streaming, one per cycle, 1-cycle latency
      got.delete();
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_vec   = 8'(1 << i);
         cyc();
         chk("stream_valid", 32'(bus.out_valid), 1);
         chk("stream_code", 32'(bus.out_code), 32'(i));
      end
      bus.in_valid = 1'b0;
      cyc();
      cyc();
      chk("stream_count", 32'(got.size()), 8);
      chk("stream_errcnt", 32'(bus.err_cnt), 0);

      // Malformed vectors
      bus.in_valid = 1'b1;
      bus.in_vec   = 8'b0000_0000;
      cyc();
      chk("zero_code", 32'(bus.out_code), 0);
      chk("zero_err", 32'(bus.out_err), 1);
      bus.in_vec = 8'b0010_1000;
      cyc();
      chk("multi_code", 32'(bus.out_code), 3);
      chk("multi_err", 32'(bus.out_err), 1);
      bus.in_valid = 1'b0;
      cyc();
      chk("mal_errcnt", 32'(bus.err_cnt), 2);
      cyc();

      // Backpressure: only two accepts with out_ready low
      got.delete();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_vec    = 8'(1 << 5);
      cyc();
      bus.in_vec = 8'(1 << 6);
      cyc();
      chk("bp_ready_low", 32'(bus.in_ready), 0);
      bus.in_vec = 8'(1 << 7);
      cyc();
      cyc();
      chk("bp_hold_code", 32'(bus.out_code), 5);
      chk("bp_hold_ready", 32'(bus.in_ready), 0);
      bus.out_ready = 1'b1;
      cyc();
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      cyc();
      exp_bp = '{3'd5, 3'd6, 3'd7};
      chk("bp_count", 32'(got.size()), 3);
      for (int i = 0; i < 3 && i < got.size(); i++)
         chk("bp_order", 32'(got[i]), 32'(exp_bp[i]));

      // Round trip through the 3-to-8 decoder
      got.delete();
      for (int v = 0; v < 8; v++) begin
         logic [2:0] abc;
         abc          = 3'(v);
         bus.in_valid = 1'b1;
         bus.in_vec   = dec3to8(abc[2], abc[1], abc[0]);
         cyc();
      end
      bus.in_valid = 1'b0;
      cyc();
      cyc();
      chk("rt_count", 32'(got.size()), 8);
      for (int v = 0; v < 8 && v < got.size(); v++)
         chk("rt_code", 32'(got[v]), 32'(v));

      // Asynchronous reset with two malformed entries held
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_vec    = 8'h00;
      cyc();
      bus.in_vec = 8'hFF;
      cyc();
      bus.in_valid = 1'b0;
      chk("pre_rst_ready", 32'(bus.in_ready), 0);
      chk("pre_rst_errcnt", 32'(bus.err_cnt), 4);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 0);
      chk("arst_in_ready", 32'(bus.in_ready), 1);
      chk("arst_err_cnt", 32'(bus.err_cnt), 0);
      chk("arst_out_err", 32'(bus.out_err), 0);
      cyc();
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_vec    = 8'(1 << 2);
      cyc();
      chk("post_rst_valid", 32'(bus.out_valid), 1);
      chk("post_rst_code", 32'(bus.out_code), 2);
      bus.in_valid = 1'b0;
      cyc();
      cyc();

      // Counter saturation on the 4-bit instance
      bus2.in_vec   = 8'h00;
      bus2.in_valid = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (i == 14) chk("sat_mid", 32'(bus2.err_cnt), 14);
      end
      bus2.in_valid = 1'b0;
      cyc();
      chk("sat_final", 32'(bus2.err_cnt), 15);
      chk("sat_err", 32'(bus2.out_err), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/onehot_encoder.md
# onehot_encoder

Pipelined 8-to-3 (generally N-to-log2 N) one-hot encoder with valid/ready handshakes and a 2-entry skid buffer. It is the inverse of the 3-to-8 decoder stage used in the full-adder datapath: it takes one-hot decoder lines and returns the binary index {a,b,cin}. Malformed vectors (zero-hot or multi-hot) are flagged per transaction and counted in a saturating error counter for debug and observation.

## Interface
- N_IN, default 8: input vector width. Must be a power of 2 and ≥ 2. W = log2(N_IN) is a derived localparam.
- ERR_CNT_W, default 8: width of the saturating error counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept; registered.
- in_vec  in  N_IN  one-hot input, bit i means code i.
- out_valid  out  1  out_code/out_err valid.
- out_ready  in  1  downstream accepts.
- out_code  out  W  encoded index.
- out_err  out  1  input was not exactly one-hot.
- err_cnt  out  ERR_CNT_W  count of accepted malformed vectors; saturates.

## Operation
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Encoding of an accepted vector:
  - Exactly one bit set at index i: code = i, err = 0.
  - Zero bits set: code = 0, err = 1.
  - Multiple bits set: code = index of the lowest set bit, err = 1.
- Storage is a main output register plus a skid register. Occupancy FSM:
  - EMPTY:
    - accept → ONE.
  - ONE:
    - accept && transfer → ONE; main register is reloaded.
    - accept && !transfer → TWO; new entry goes to skid.
    - !accept && transfer → EMPTY.
    - Otherwise hold.
  - TWO:
    - transfer → ONE; skid moves to main.
    - Otherwise hold.
    - No accept is possible in TWO.
- in_ready = (state != TWO). It is derived from the state register only, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Ordering is strict FIFO. No entry is dropped or duplicated.
- err_cnt increments by 1 on each accept with err = 1, at the accept edge, independent of output backpressure. It holds at 2^ERR_CNT_W − 1.
- in_vec is sampled only on accept. Its value is don't-care otherwise.

## Timing
- Reset values, asynchronous on rst_n low: state = EMPTY, in_ready = 1, out_valid = 0, out_code = 0, out_err = 0, err_cnt = 0, skid contents = 0.
- Reset mid-operation discards both entries immediately. The first accept after rst_n rises is legal on the first clock edge.
- Latency: accept at edge k → out_valid = 1 with that result after edge k, i.e. visible in cycle k+1.
- Throughput: 1 transaction per cycle while out_ready = 1.
- With out_ready held low, at most 2 accepts occur. in_ready falls in the cycle after the second accept.
- While out_valid = 1 && out_ready = 0, out_code and out_err are stable.
- Simultaneous accept and transfer in ONE is a legal full-rate case and must not pass through TWO.

## Structure
- Shared package onehot_pkg holds:
  - Occupancy enum {EMPTY, ONE, TWO}.
  - A function returning {code, err} for an N_IN-bit vector (lowest-set-bit priority, popcount ≠ 1 → err), so the encode rule is defined once.
- Sub-module onehot_encoder_core: purely combinational in_vec → {code, err}. The top instantiates it once and owns the FSM, registers and counter.

## Test plan
- Reset: assert rst_n = 0 mid-stream with 2 entries held → out_valid = 0, in_ready = 1, err_cnt = 0 immediately, before the next clk edge.
- Streaming: 8'b0000_0001 … 8'b1000_0000 on consecutive cycles, out_ready = 1 → out_code 0…7, one per cycle, 1-cycle latency, out_err = 0, err_cnt = 0.
- Malformed inputs: 8'b0000_0000 → code 0, err 1. Then 8'b0010_1000 → code 3, err 1. err_cnt = 2 afterwards.
- Backpressure: out_ready = 0 for 4 cycles with in_valid = 1 carrying codes 5, 6, 7 → only 5 and 6 accepted, in_ready = 0 thereafter. On release, outputs are 5, 6, then 7, in order.
- Counter saturation: ERR_CNT_W = 4, 20 accepted zero vectors → err_cnt stops at 15.
- Round trip: drive all 8 {a,b,cin} values through the existing 3-to-8 decoder into this block → out_code equals the original {a,b,cin} for every value.
